// File: rtl/frame_slot_scheduler.sv
// Triple-buffer frame slot manager: writer always owns one slot, reader gets the newest complete frame; all outputs registered, 1-cycle latency.
// Optional dropped-frame counter enabled by FRAME_DROP_CNT_EN; otherwise dropped_frames is tied to 0.
module frame_slot_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pixels_per_frame,
  input  logic                  wr_frame_done,
  output logic                  wr_slot_valid,
  output logic [ADDR_WIDTH-1:0] wr_slot_base,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic [ADDR_WIDTH-1:0] rd_slot_base,
  input  logic                  rd_frame_done,
  output logic [5:0]            slot_state,
  output logic [CNT_WIDTH-1:0]  dropped_frames
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_WRITING = 2'd1,
    S_READY   = 2'd2,
    S_READING = 2'd3
  } slot_e;

  localparam int PW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  slot_e                 st_q [3];
  slot_e                 st_d [3];
  logic                  wr_vld_q;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
  logic                  rd_grant_q, rd_grant_d;
  logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;

  logic [1:0] wr_idx, rdy_idx, rding_idx, free_idx, nxt_wr_idx;
  logic       has_rdy, has_rding, grant, drop;

  // Base = stride * idx, with idx limited to 0..2 so a shift replaces the multiply.
  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] idx, input logic [31:0] ppf);
    logic [PW:0] ext;
    ext = (PW+1)'(ppf);
    if (idx == 2'd0)      ext = '0;
    else if (idx == 2'd2) ext = ext << 1;
    return ext[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    st_d       = st_q;
    wr_idx     = '0;
    rdy_idx    = '0;
    rding_idx  = '0;
    free_idx   = '0;
    has_rdy    = 1'b0;
    has_rding  = 1'b0;
    drop       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (st_q[i] == S_WRITING) wr_idx = 2'(i);
      if (st_q[i] == S_READY) begin
        rdy_idx = 2'(i);
        has_rdy = 1'b1;
      end
      if (st_q[i] == S_READING) begin
        rding_idx = 2'(i);
        has_rding = 1'b1;
      end
    end
    grant = rd_req && has_rdy && !has_rding;

    if (rd_frame_done && has_rding) st_d[rding_idx] = S_FREE;
    if (grant) st_d[rdy_idx] = S_READING;

    if (wr_frame_done) begin
      // A READY slot taken by a same-cycle grant is not a drop.
      if (has_rdy && !grant) begin
        st_d[rdy_idx] = S_FREE;
        drop          = 1'b1;
      end
      st_d[wr_idx] = S_READY;
      for (int i = 2; i >= 0; i--) begin
        if (st_d[i] == S_FREE) free_idx = 2'(i);
      end
      st_d[free_idx] = S_WRITING;
    end

    nxt_wr_idx = wr_frame_done ? free_idx : wr_idx;
    wr_base_d  = base_of(nxt_wr_idx, pixels_per_frame);
    rd_grant_d = grant;
    rd_base_d  = grant ? base_of(rdy_idx, pixels_per_frame) : rd_base_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]    <= S_WRITING;
      st_q[1]    <= S_FREE;
      st_q[2]    <= S_FREE;
      wr_vld_q   <= 1'b0;
      wr_base_q  <= '0;
      rd_grant_q <= 1'b0;
      rd_base_q  <= '0;
    end else begin
      st_q       <= st_d;
      wr_vld_q   <= 1'b1;
      wr_base_q  <= wr_base_d;
      rd_grant_q <= rd_grant_d;
      rd_base_q  <= rd_base_d;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_frames = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop    = drop;
  assign dropped_frames = '0;
`endif

  assign wr_slot_valid = wr_vld_q;
  assign wr_slot_base  = wr_base_q;
  assign rd_grant      = rd_grant_q;
  assign rd_slot_base  = rd_base_q;
  assign slot_state    = {st_q[2], st_q[1], st_q[0]};

endmodule

// File: doc/frame_slot_scheduler.md
# frame_slot_scheduler

Triple-buffer slot manager for the frame store in external memory. It hands the stream-to-memory writer a free frame slot base address and retires each slot when the writer signals end of frame. It grants the newest complete frame to the downstream frame reader and frees that slot when the reader finishes. The writer never overwrites a slot that is being read, and the reader never sees a partially written frame.

## Interface
- ADDR_WIDTH, 32, width of slot base addresses
- CNT_WIDTH, 16, width of the dropped-frame counter
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pixels_per_frame  in  32  slot stride; quasi-static, changed only while idle
- wr_frame_done  in  1  one-cycle pulse: writer finished its current slot
- wr_slot_valid  out  1  writer may write to wr_slot_base
- wr_slot_base  out  ADDR_WIDTH  base address of the writer's slot
- rd_req  in  1  level; reader wants a frame, held until rd_grant
- rd_grant  out  1  one-cycle pulse: frame granted
- rd_slot_base  out  ADDR_WIDTH  base address of the granted slot, stable until the next grant
- rd_frame_done  in  1  one-cycle pulse: reader finished the granted slot
- slot_state  out  6  2 bits per slot {slot2,slot1,slot0}: 0 FREE, 1 WRITING, 2 READY, 3 READING
- dropped_frames  out  CNT_WIDTH  frames overwritten unread (macro-dependent)

## Operation
- Three slots, idx 0..2. Slot base = pixels_per_frame × idx, truncated to ADDR_WIDTH.
- Per-slot state machine: FREE → WRITING → READY → READING → FREE. A READY slot returns to FREE when it is superseded.
- Invariants: exactly one WRITING slot, at most one READY slot, at most one READING slot.
- On wr_frame_done:
  - The WRITING slot becomes READY.
  - Any previous READY slot becomes FREE and dropped_frames increments.
  - The lowest-index FREE slot becomes WRITING and drives wr_slot_base.
  - A FREE slot always exists, so wr_slot_valid stays 1.
- Read grant conditions: rd_req=1, no slot in READING, and a READY slot exists. All three are evaluated on the current-cycle state.
- On grant: the READY slot becomes READING, rd_grant pulses, and rd_slot_base loads.
- rd_frame_done with a READING slot: that slot becomes FREE. With no READING slot: ignored.
- Same-cycle wr_frame_done and grant:
  - The grant takes the old READY slot.
  - The newly finished slot becomes READY with no drop counted.
- Same-cycle rd_frame_done and rd_req: the slot is freed, and the grant is evaluated next cycle.
- dropped_frames saturates at all-ones.

## Timing
- All outputs are registered.
- Reset values:
  - slot0 WRITING, slots 1 and 2 FREE, so slot_state=6'b000001.
  - wr_slot_valid=0, wr_slot_base=0, rd_grant=0, rd_slot_base=0, dropped_frames=0.
- wr_slot_valid rises 1 on the first clk edge after rst_n deasserts and then stays 1.
- wr_slot_base updates 1 cycle after wr_frame_done.
- rd_grant and rd_slot_base assert 1 cycle after the grant condition is true.
- rd_req must drop or be re-evaluated after rd_grant. A held rd_req does not re-grant while a slot is READING.
- Minimum 2 cycles between consecutive grants.
- rst_n assertion mid-frame immediately returns all state to reset values. In-flight writer and reader transfers are abandoned.

## Configuration
- FRAME_DROP_CNT_EN defined: dropped_frames counter implemented as above.
- FRAME_DROP_CNT_EN undefined: no counter logic; dropped_frames tied to 0. Slot behaviour is otherwise identical.

## Test plan
- Reset and idle: pixels_per_frame=921600, rst_n released → wr_slot_valid=1 after 1 cycle, wr_slot_base=0, slot_state=6'b000001.
- Write then read: wr_frame_done, then rd_req → wr_slot_base=921600, and rd_grant pulses with rd_slot_base=0. After rd_frame_done, slot0 is FREE.
- Drop path, no reader: 3 wr_frame_done pulses → writer cycles through slots 0→1→0→1 (bases 0, 921600, 0, 921600), and dropped_frames=2.
- Read protection: grant slot0, then issue 4 wr_frame_done pulses → slot0 stays READING and the writer alternates between slots 1 and 2. dropped_frames=3 with the macro, 0 without.
- Simultaneous events: slot1 READY, and wr_frame_done coincides with rd_req → slot1 granted, slot2 READY, dropped_frames unchanged.
- Reset mid-operation: rst_n pulsed low while a slot is READING → slot_state=6'b000001 and rd_grant=0. A pending rd_req is not granted until a new wr_frame_done.
